// File: rtl/nios_fprint_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_fprint_mem_pkg
// Purpose  : Shared constants and helper functions for the fingerprint
//            dual-port on-chip memory.
//            - MAX_READ_LATENCY : deepest supported read pipeline
//            - be_merge()       : byte-lane merge of a write into a word
//            - byte_parity()    : even-parity bit per byte lane
//            The helpers work on a MAX_DATA_W-wide word. Callers size-cast
//            their DATA_W operands up and the result back down.
// Revision : 1.0 - initial release
// ============================================================================
package nios_fprint_mem_pkg;

    localparam int MAX_READ_LATENCY = 2;
    localparam int MAX_DATA_W       = 256;
    localparam int MAX_BE_W         = MAX_DATA_W / 8;

    // Replace the lanes whose enable bit is set. Keep every other lane.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Each result bit is set so that the byte plus the bit holds an even
    // number of ones.
    function automatic logic [MAX_BE_W-1:0] byte_parity(
        input logic [MAX_DATA_W-1:0] data
    );
        logic [MAX_BE_W-1:0] par;
        par = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            par[i] = ^data[i*8 +: 8];
        end
        return par;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios_fprint_mem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : nios_fprint_mem_rd_pipe
// Purpose  : DEPTH-stage valid/data shift register carrying read results.
//            The pipeline advances only while en=1. While en=0 it holds its
//            contents and the output valid is masked.
// Ports    : clk, reset_n (async active-low), en,
//            in_valid/in_data  - accepted read and raw RAM word
//            out_valid/out_data - delayed result
// Revision : 1.0 - initial release
// ============================================================================
module nios_fprint_mem_rd_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            d <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            if (in_valid) begin
                d[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                // Data moves only with a valid token. Idle stages keep their
                // last value, which avoids needless toggling.
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

    // Masking with en gives exactly one pulse per read. A stalled result
    // shows on the next enabled cycle and then shifts out.
    assign out_valid = v[DEPTH-1] & en;
    assign out_data  = d[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/nios_fprint_onchip_memory_dp.sv
`default_nettype none
// ============================================================================
// Module   : nios_fprint_onchip_memory_dp
// Purpose  : True-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2).
//            Provides a READ_LATENCY read pipeline (1 or 2), byte-enabled
//            posted writes and write-write collision arbitration. On a
//            collision s1 wins and s2 is stalled for one cycle.
// Ports    : clk, reset_n (async active-low), clken, reset_req
//            s1_/s2_ chipselect, write, address, byteenable, writedata
//            s1_/s2_ readdata, readdatavalid, waitrequest (s1 tied 0)
//            parity_err (sticky; tied 0 unless parity is enabled)
// Config   : NIOS_FPRINT_ONCHIP_MEM_PARITY_EN adds per-byte even parity.
// Revision : 1.0 - initial release
// ============================================================================
module nios_fprint_onchip_memory_dp
    import nios_fprint_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 10,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic                reset_req,
    input  logic                s1_chipselect,
    input  logic                s1_write,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic                s2_chipselect,
    input  logic                s2_write,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
`ifdef NIOS_FPRINT_ONCHIP_MEM_PARITY_EN
    localparam int PIPE_W = DATA_W + NB;
`else
    localparam int PIPE_W = DATA_W;
`endif

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_read_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8 and at most MAX_DATA_W");
    end
    if (INIT_FILE != "") begin : g_init_file
        // The device implementation flow loads the file through its
        // memory-initialisation attribute. The RTL itself stays init-free.
        $info("on-chip memory init file: %s", INIT_FILE);
    end

    logic [DATA_W-1:0] mem [DEPTH];

    // Accept / arbitration. Requests are also gated by reset_n, so the RAM
    // stays untouched while reset is held. The first request is accepted on
    // the first edge after release.
    logic en;
    logic s2_collide;
    logic s1_accept, s2_accept;
    logic s1_wr, s1_rd, s2_wr, s2_rd;

    assign en         = clken & ~reset_req;
    assign s2_collide = en & s1_chipselect & s1_write & s2_chipselect & s2_write
                      & (s1_address == s2_address);

    assign s1_waitrequest = 1'b0;
    assign s2_waitrequest = s2_collide & reset_n;

    assign s1_accept = s1_chipselect & en & reset_n;
    assign s2_accept = s2_chipselect & en & reset_n & ~s2_collide;
    assign s1_wr     = s1_accept & s1_write;
    assign s1_rd     = s1_accept & ~s1_write;
    assign s2_wr     = s2_accept & s2_write;
    assign s2_rd     = s2_accept & ~s2_write;

    logic [DATA_W-1:0] s1_merged, s2_merged;
    assign s1_merged = DATA_W'(be_merge(MAX_DATA_W'(mem[s1_address]),
                                        MAX_DATA_W'(s1_writedata),
                                        MAX_BE_W'(s1_byteenable)));
    assign s2_merged = DATA_W'(be_merge(MAX_DATA_W'(mem[s2_address]),
                                        MAX_DATA_W'(s2_writedata),
                                        MAX_BE_W'(s2_byteenable)));

`ifdef NIOS_FPRINT_ONCHIP_MEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] s1_par_new, s2_par_new;

    assign s1_par_new = (par_mem[s1_address] & ~s1_byteenable)
                      | (NB'(byte_parity(MAX_DATA_W'(s1_writedata))) & s1_byteenable);
    assign s2_par_new = (par_mem[s2_address] & ~s2_byteenable)
                      | (NB'(byte_parity(MAX_DATA_W'(s2_writedata))) & s2_byteenable);
`endif

    // Both write ports sit in one process. Only one port can write a given
    // address in a cycle, because an s2 collision is stalled. Reads of the
    // same address in the same cycle see the old word.
    always_ff @(posedge clk) begin
        if (s1_wr) begin
            mem[s1_address] <= s1_merged;
`ifdef NIOS_FPRINT_ONCHIP_MEM_PARITY_EN
            par_mem[s1_address] <= s1_par_new;
`endif
        end
        if (s2_wr) begin
            mem[s2_address] <= s2_merged;
`ifdef NIOS_FPRINT_ONCHIP_MEM_PARITY_EN
            par_mem[s2_address] <= s2_par_new;
`endif
        end
    end

    logic [PIPE_W-1:0] s1_pipe_in, s2_pipe_in, s1_pipe_out, s2_pipe_out;
`ifdef NIOS_FPRINT_ONCHIP_MEM_PARITY_EN
    assign s1_pipe_in = {par_mem[s1_address], mem[s1_address]};
    assign s2_pipe_in = {par_mem[s2_address], mem[s2_address]};
`else
    assign s1_pipe_in = mem[s1_address];
    assign s2_pipe_in = mem[s2_address];
`endif

    nios_fprint_mem_rd_pipe #(.WIDTH(PIPE_W), .DEPTH(READ_LATENCY)) u_s1_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .in_valid  (s1_rd),
        .in_data   (s1_pipe_in),
        .out_valid (s1_readdatavalid),
        .out_data  (s1_pipe_out)
    );

    nios_fprint_mem_rd_pipe #(.WIDTH(PIPE_W), .DEPTH(READ_LATENCY)) u_s2_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .in_valid  (s2_rd),
        .in_data   (s2_pipe_in),
        .out_valid (s2_readdatavalid),
        .out_data  (s2_pipe_out)
    );

    assign s1_readdata = s1_pipe_out[DATA_W-1:0];
    assign s2_readdata = s2_pipe_out[DATA_W-1:0];

`ifdef NIOS_FPRINT_ONCHIP_MEM_PARITY_EN
    // Recompute parity on the delivered word and compare it with the stored
    // bits. The data itself goes out unmodified.
    logic s1_par_bad, s2_par_bad;
    logic parity_err_r;

    assign s1_par_bad = NB'(byte_parity(MAX_DATA_W'(s1_readdata))) != s1_pipe_out[PIPE_W-1:DATA_W];
    assign s2_par_bad = NB'(byte_parity(MAX_DATA_W'(s2_readdata))) != s2_pipe_out[PIPE_W-1:DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_r <= 1'b0;
        end else if ((s1_readdatavalid && s1_par_bad) || (s2_readdatavalid && s2_par_bad)) begin
            parity_err_r <= 1'b1;
        end
    end
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios_fprint_onchip_memory_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_fprint_onchip_memory_dp
// Purpose  : Directed self-checking bench for nios_fprint_onchip_memory_dp
//            (DATA_W=32, ADDR_W=10, READ_LATENCY=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_fprint_onchip_memory_dp;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        reset_n, clken, reset_req;
    logic        s1_chipselect, s1_write, s2_chipselect, s2_write;
    logic [9:0]  s1_address, s2_address;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid;
    logic        s1_waitrequest, s2_waitrequest;
    logic        parity_err;

    int tests = 0;
    int fails = 0;

    logic        mon_en = 1'b0;
    logic [31:0] mon_q[$];

    always #5 clk = ~clk;

    nios_fprint_onchip_memory_dp #(
        .DATA_W(32), .ADDR_W(10), .READ_LATENCY(RL), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .s1_chipselect(s1_chipselect), .s1_write(s1_write), .s1_address(s1_address),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s1_waitrequest(s1_waitrequest),
        .s2_chipselect(s2_chipselect), .s2_write(s2_write), .s2_address(s2_address),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
        .s2_waitrequest(s2_waitrequest),
        .parity_err(parity_err)
    );

    // Capture s1 results away from the clock edge.
    always @(negedge clk) begin
        if (mon_en && s1_readdatavalid) mon_q.push_back(s1_readdata);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic cs, input logic wr,
                         input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        if (port == 1) begin
            s1_chipselect = cs; s1_write = wr; s1_address = a;
            s1_byteenable = be; s1_writedata = d;
        end else begin
            s2_chipselect = cs; s2_write = wr; s2_address = a;
            s2_byteenable = be; s2_writedata = d;
        end
    endtask

    function automatic logic valid_of(input int port);
        return (port == 1) ? s1_readdatavalid : s2_readdatavalid;
    endfunction

    function automatic logic [31:0] rdata_of(input int port);
        return (port == 1) ? s1_readdata : s2_readdata;
    endfunction

    task automatic wr(input int port, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(port, 1'b1, 1'b1, a, be, d);
        tick;
        drive(port, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    endtask

    // Wait for the result after an accept edge and check latency and data.
    task automatic wait_result(input int port, input logic [31:0] exp, input string tag);
        int lat;
        lat = 1;
        while (!valid_of(port) && lat < 8) begin
            tick;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(RL));
        check({tag, "_data"}, 64'(rdata_of(port)), 64'(exp));
    endtask

    task automatic rd(input int port, input logic [9:0] a, input logic [31:0] exp, input string tag);
        drive(port, 1'b1, 1'b0, a, 4'h0, 32'h0);
        tick;
        drive(port, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        wait_result(port, exp, tag);
    endtask

    initial begin
        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        drive(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        repeat (3) tick;

        // Reset state
        check("rst_s1_valid", 64'(s1_readdatavalid), 64'd0);
        check("rst_s2_valid", 64'(s2_readdatavalid), 64'd0);
        check("rst_s1_rdata", 64'(s1_readdata), 64'd0);
        check("rst_s2_wait",  64'(s2_waitrequest), 64'd0);
        check("rst_par_err",  64'(parity_err), 64'd0);

        // The first write is presented with the release and accepted on the next edge.
        reset_n = 1'b1;
        wr(1, 10'h005, 32'hDEADBEEF, 4'hF);
        rd(1, 10'h005, 32'hDEADBEEF, "s1_rd_005");
        rd(2, 10'h005, 32'hDEADBEEF, "s2_rd_005");

        // Byte enables: lanes 0 and 2 replaced.
        wr(1, 10'h010, 32'h11223344, 4'hF);
        wr(1, 10'h010, 32'hAABBCCDD, 4'h5);
        rd(2, 10'h010, 32'h11BB33DD, "be_merge");

        // Write-write collision at the last word.
        drive(1, 1'b1, 1'b1, 10'h3FF, 4'hF, 32'h0000FFFF);
        drive(2, 1'b1, 1'b1, 10'h3FF, 4'hF, 32'hFFFF0000);
        #1;
        check("coll_wait_hi", 64'(s2_waitrequest), 64'd1);
        check("coll_s1_wait", 64'(s1_waitrequest), 64'd0);
        tick;
        drive(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        #1;
        check("coll_wait_lo", 64'(s2_waitrequest), 64'd0);
        tick;
        drive(2, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        rd(1, 10'h3FF, 32'hFFFF0000, "coll_final");

        // Mixed-port read-during-write returns old data.
        wr(1, 10'h020, 32'h00000001, 4'hF);
        drive(1, 1'b1, 1'b1, 10'h020, 4'hF, 32'h00000002);
        drive(2, 1'b1, 1'b0, 10'h020, 4'h0, 32'h0);
        #1;
        check("rdw_no_wait", 64'(s2_waitrequest), 64'd0);
        tick;
        drive(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        wait_result(2, 32'h00000001, "rdw_old");
        rd(2, 10'h020, 32'h00000002, "rdw_new");

        // Back-to-back reads with clken dropped for one cycle.
        for (int i = 0; i < 4; i++) wr(2, 10'(10'h040 + i), 32'(32'hA0 + i), 4'hF);
        mon_q.delete();
        mon_en = 1'b1;
        drive(1, 1'b1, 1'b0, 10'h040, 4'h0, 32'h0); tick;
        drive(1, 1'b1, 1'b0, 10'h041, 4'h0, 32'h0); tick;
        clken = 1'b0;
        drive(1, 1'b1, 1'b0, 10'h042, 4'h0, 32'h0); tick;
        clken = 1'b1;
        tick;
        drive(1, 1'b1, 1'b0, 10'h043, 4'h0, 32'h0); tick;
        drive(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        repeat (3) tick;
        check("stall_count", 64'(mon_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < mon_q.size()) check($sformatf("stall_q%0d", i), 64'(mon_q[i]), 64'(32'hA0 + i));
            else                  check($sformatf("stall_q%0d", i), 64'hFFFF_FFFF_FFFF_FFFF, 64'(32'hA0 + i));
        end

        // Asynchronous reset in the middle of a read burst.
        drive(1, 1'b1, 1'b0, 10'h040, 4'h0, 32'h0); tick;
        drive(1, 1'b1, 1'b0, 10'h041, 4'h0, 32'h0); tick;
        reset_n = 1'b0;
        drive(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        mon_q.delete();
        #1;
        check("mid_rst_valid", 64'(s1_readdatavalid), 64'd0);
        check("mid_rst_rdata", 64'(s1_readdata), 64'd0);
        repeat (2) tick;
        reset_n = 1'b1;
        repeat (3) tick;
        check("mid_rst_no_valids", 64'(mon_q.size()), 64'd0);
        mon_en = 1'b0;
        rd(1, 10'h041, 32'h000000A1, "keep_041");
        rd(2, 10'h005, 32'hDEADBEEF, "keep_005");

        // reset_req freezes writes and reads.
        wr(1, 10'h050, 32'h00000055, 4'hF);
        reset_req = 1'b1;
        drive(1, 1'b1, 1'b1, 10'h050, 4'hF, 32'h00000066);
        drive(2, 1'b1, 1'b0, 10'h050, 4'h0, 32'h0);
        tick;
        check("rreq_s2_valid", 64'(s2_readdatavalid), 64'd0);
        drive(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        reset_req = 1'b0;
        rd(1, 10'h050, 32'h00000055, "rreq_no_write");

`ifdef NIOS_FPRINT_ONCHIP_MEM_PARITY_EN
        wr(1, 10'h030, 32'h12345678, 4'hF);
        rd(1, 10'h030, 32'h12345678, "par_clean");
        check("par_clean_err", 64'(parity_err), 64'd0);
        dut.mem[48][0] = ~dut.mem[48][0];
        rd(1, 10'h030, 32'h12345679, "par_flip");
        tick;
        check("par_err_set", 64'(parity_err), 64'd1);
        repeat (3) tick;
        check("par_err_sticky", 64'(parity_err), 64'd1);
        reset_n = 1'b0;
        #1;
        check("par_err_clr", 64'(parity_err), 64'd0);
        tick;
        reset_n = 1'b1;
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
